// File: rtl/simon_arb_ctrl.sv
// Two-requester round-robin front end for a shared Simon 32/64 engine.
// The engine gets a start pulse, is watched for done (or a timeout), and the result goes back to the winner.
module simon_arb_ctrl #(
  parameter int CORE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_pt,
  input  logic [63:0] req0_key,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_ct,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_pt,
  input  logic [63:0] req1_key,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_ct,
  output logic        rsp1_err,
  output logic        core_start,
  output logic [31:0] core_pt,
  output logic [63:0] core_key,
  input  logic        core_done,
  input  logic [31:0] core_ct
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(CORE_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [31:0] pt_q, pt_nxt;
  logic [63:0] key_q, key_nxt;
  logic [31:0] ct_q, ct_nxt;
  logic        err_q, err_nxt;
  logic        winner;
  logic        accept;
  logic        rsp_taken;

  // On a tie the requester that did not win last time goes first.
  assign winner     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  // Gated by rst_n so the readies read 0 while reset is held, even with valids high.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !winner;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && winner;
  assign accept     = req0_ready || req1_ready;
  assign rsp_taken  = gnt ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == RESP) && !gnt;
  assign rsp1_valid = (state == RESP) && gnt;
  assign rsp0_ct    = rsp0_valid ? ct_q : 32'h0;
  assign rsp1_ct    = rsp1_valid ? ct_q : 32'h0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;
  assign core_pt    = pt_q;
  assign core_key   = key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      timer      <= 8'h0;
      pt_q       <= 32'h0;
      key_q      <= 64'h0;
      ct_q       <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_grant_nxt;
      timer      <= timer_nxt;
      pt_q       <= pt_nxt;
      key_q      <= key_nxt;
      ct_q       <= ct_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    pt_nxt         = pt_q;
    key_nxt        = key_q;
    ct_nxt         = ct_q;
    err_nxt        = err_q;
    core_start     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pt_nxt    = winner ? req1_pt  : req0_pt;
          key_nxt   = winner ? req1_key : req0_key;
          gnt_nxt   = winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        timer_nxt  = 8'h0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + 8'h1;
        // A done landing on the timeout cycle still counts as a good result.
        if (core_done) begin
          ct_nxt    = core_ct;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (timer == TMO_LAST) begin
          ct_nxt    = 32'h0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_taken) begin
          last_grant_nxt = gnt;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
